// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// One nibble at a time goes to a shared hex decoder. The matching anode and
// decimal point are driven active-low. A blanking gap opens every digit slot.
// New values are double-buffered and only swap in at frame boundaries.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    lz_en,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Scan position
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;

    // Displayed and pending buffers
    logic [NUM_DIGITS-1:0][3:0] active_value_reg, active_value_next;
    logic [NUM_DIGITS-1:0]      active_dp_reg, active_dp_next;
    logic [NUM_DIGITS-1:0][3:0] pend_value_reg;
    logic [NUM_DIGITS-1:0]      pend_dp_reg;
    logic                       pend_full_reg, pend_full_next;

    // Registered outputs
    logic [3:0]            nibble_reg, nibble_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic                  dp_n_reg, dp_n_next;
    logic                  frame_done_reg, frame_done_next;
    logic                  load_ready_reg, load_ready_next;

    logic                  load_accept;
    logic                  boundary;
    logic [NUM_DIGITS-1:0] nib_zero;
    logic [NUM_DIGITS-1:0] suppress;

    assign load_accept = load_valid && !pend_full_reg;

    // The last cycle of the last digit's slot. The buffer swap happens on
    // the edge that ends this cycle. This is the same cycle in which
    // frame_done is high.
    assign boundary = (state_reg == SHOW) && (idx_reg == IDX_LAST) &&
                      (cnt_reg == CNT_LAST);

    // Scan state machine register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state logic: blank then show within each slot, and advance the digit at slot end
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
                BLANK: begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_reg == CNT_LAST) begin
                        state_next = BLANK;
                        cnt_next   = '0;
                        idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Buffer bookkeeping: promote pending to active at a boundary, otherwise accept a load.
    // While the pending buffer is full, load_ready is low, so these two cases never collide.
    always_comb begin
        active_value_next = active_value_reg;
        active_dp_next    = active_dp_reg;
        pend_full_next    = pend_full_reg;
        if (boundary && pend_full_reg) begin
            active_value_next = pend_value_reg;
            active_dp_next    = pend_dp_reg;
            pend_full_next    = 1'b0;
        end else if (load_accept) begin
            pend_full_next = 1'b1;
        end
    end

    // Active buffer and pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_value_reg <= '0;
            active_dp_reg    <= '0;
            pend_full_reg    <= 1'b0;
        end else begin
            active_value_reg <= active_value_next;
            active_dp_reg    <= active_dp_next;
            pend_full_reg    <= pend_full_next;
        end
    end

    // Pending buffer captures a value whenever a load is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
        end else if (load_accept) begin
            pend_value_reg <= load_value;
            pend_dp_reg    <= load_dp;
        end
    end

    // Per-digit zero flags for the value that will be displayed after this edge
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
        assign nib_zero[gi] = (active_value_next[gi] == 4'h0);
    end

    // A digit is blanked as a leading zero when it and every digit above it
    // are zero and its own decimal point is off. Digit 0 always shows.
    assign suppress[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_supp
        assign suppress[gi] = lz_en && (&nib_zero[NUM_DIGITS-1:gi]) &&
                              !active_dp_next[gi];
    end

    // Output decode from the next scan position, so the registered outputs match the state after each edge
    always_comb begin
        nibble_next     = nibble_reg;
        an_next         = '1;
        dp_n_next       = 1'b1;
        frame_done_next = 1'b0;
        load_ready_next = !pend_full_next;
        if (state_next != IDLE) begin
            nibble_next = active_value_next[idx_next];
        end
        if ((state_next == SHOW) && !suppress[idx_next]) begin
            an_next   = ~(NUM_DIGITS'(1) << idx_next);
            dp_n_next = !active_dp_next[idx_next];
        end
        frame_done_next = (state_next == SHOW) && (idx_next == IDX_LAST) &&
                          (cnt_next == CNT_LAST);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nibble_reg     <= 4'h0;
            an_reg         <= '1;
            dp_n_reg       <= 1'b1;
            frame_done_reg <= 1'b0;
            load_ready_reg <= 1'b1;
        end else begin
            nibble_reg     <= nibble_next;
            an_reg         <= an_next;
            dp_n_reg       <= dp_n_next;
            frame_done_reg <= frame_done_next;
            load_ready_reg <= load_ready_next;
        end
    end

    assign nibble     = nibble_reg;
    assign an         = an_reg;
    assign dp_n       = dp_n_reg;
    assign frame_done = frame_done_reg;
    assign load_ready = load_ready_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl. The reference model describes the
// scan as an elapsed-cycle position that runs from when the scan starts.
// The digit, the blank/show phase and the frame end are all derived from
// that position with division and modulo.
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int TD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * TD;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        lz_en;
    logic [15:0] load_value;
    logic [3:0]  load_dp;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp_n;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_run;
    int          m_pos;
    logic [15:0] m_act, m_pend;
    logic [3:0]  m_act_dp, m_pend_dp;
    bit          m_full;
    logic [3:0]  m_nib;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (TD),
        .BLANK_CYC (BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .lz_en     (lz_en),
        .load_value(load_value),
        .load_dp   (load_dp),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .nibble    (nibble),
        .an        (an),
        .dp_n      (dp_n),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        m_pos     = 0;
        m_act     = '0;
        m_pend    = '0;
        m_act_dp  = '0;
        m_pend_dp = '0;
        m_full    = 1'b0;
        m_nib     = '0;
    endtask

    // Advance the model by one clock edge using the inputs now on the pins
    task automatic model_step();
        if (m_run && (m_pos % FRAME) == FRAME - 1 && m_full) begin
            m_act    = m_pend;
            m_act_dp = m_pend_dp;
            m_full   = 1'b0;
            $display("promote value=%h dp=%b", m_act, m_act_dp);
        end else if (load_valid && !m_full) begin
            m_pend    = load_value;
            m_pend_dp = load_dp;
            m_full    = 1'b1;
            $display("load value=%h dp=%b", load_value, load_dp);
        end
        if (!enable) begin
            m_run = 1'b0;
            m_pos = 0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_pos = 0;
        end else begin
            m_pos++;
        end
        if (m_run) m_nib = m_act[4*((m_pos / TD) % ND) +: 4];
    endtask

    // Compare every output against what the model says should be showing
    task automatic compare_all();
        int         d, off;
        bit         supp;
        logic [3:0] e_an;
        logic       e_dp, e_fd;
        e_an = 4'hF;
        e_dp = 1'b1;
        e_fd = 1'b0;
        if (m_run) begin
            d    = (m_pos / TD) % ND;
            off  = m_pos % TD;
            supp = (d >= 1) && lz_en && ((m_act >> (4 * d)) == 16'h0) && !m_act_dp[d];
            if (off >= BC && !supp) begin
                e_an = ~(4'b0001 << d);
                e_dp = ~m_act_dp[d];
            end
            e_fd = (d == ND - 1) && (off == TD - 1);
        end
        check("an", an, e_an);
        check("dp_n", dp_n, e_dp);
        check("nibble", nibble, m_nib);
        check("frame_done", frame_done, e_fd);
        check("load_ready", load_ready, !m_full);
    endtask

    task automatic cycle();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    // Reset in the middle of a cycle: outputs must go to reset values at once
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_nibble", nibble, 4'h0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_load_ready", load_ready, 1'b1);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    task automatic load_once(input logic [15:0] v, input logic [3:0] dp);
        load_valid = 1'b1;
        load_value = v;
        load_dp    = dp;
        cycle();
        load_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        lz_en      = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        load_dp    = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Plain scan of zeros
        enable = 1'b1;
        repeat (2 * FRAME + 4) cycle();

        // Mid-frame load with a decimal point on digit 2
        load_once(16'h12A5, 4'b0100);
        repeat (2 * FRAME) cycle();

        // Leading-zero suppression, without and then with a dp on digit 2
        lz_en = 1'b1;
        load_once(16'h0007, 4'b0000);
        repeat (2 * FRAME) cycle();
        load_once(16'h0007, 4'b0100);
        repeat (2 * FRAME) cycle();

        // Back-to-back loads: the second waits for the promotion
        load_valid = 1'b1;
        load_value = 16'hA0A0;
        load_dp    = 4'b0001;
        cycle();
        load_value = 16'h0505;
        load_dp    = 4'b1000;
        repeat (FRAME + 4) cycle();
        load_valid = 1'b0;
        repeat (2 * FRAME) cycle();

        // Drop enable in the middle of digit 2's SHOW, then resume
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_run && (m_pos / TD) % ND == 2 && (m_pos % TD) >= BC + 1) break;
            cycle();
        end
        enable = 1'b0;
        repeat (3) cycle();
        enable = 1'b1;
        repeat (FRAME + 2) cycle();

        // Reset while a pending value is held
        load_once(16'h9999, 4'b1111);
        repeat (TD + 3) cycle();
        async_reset();
        repeat (2 * FRAME) cycle();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (enable) begin
                if ($urandom_range(0, 149) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                enable = 1'b1;
            end
            if ($urandom_range(0, 59) == 0) lz_en = ~lz_en;
            load_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       load_value = 16'($urandom) & 16'h000F;
                1:       load_value = 16'($urandom) & 16'h00FF;
                2:       load_value = 16'($urandom) & 16'h0FFF;
                default: load_value = 16'($urandom);
            endcase
            load_dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 699) == 0) async_reset();
            else cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
